// File: rtl/div_bus_pkg.sv
// Shared definitions for the divider bus master: register map, FSM states, error result.
package div_bus_pkg;

   // Word addresses of the divider peripheral registers
   localparam logic [2:0] DIV_A      = 3'd0;
   localparam logic [2:0] DIV_B      = 3'd1;
   localparam logic [2:0] DIV_INIT   = 3'd2;
   localparam logic [2:0] DIV_READY  = 3'd3;
   localparam logic [2:0] DIV_RESULT = 3'd4;

   // Quotient reported for a zero divisor (no bus traffic is generated)
   localparam logic [31:0] ERR_DIV0_RESULT = 32'hFFFF_FFFF;

   typedef enum logic [3:0] {
      S_IDLE,
      S_W_INIT0,
      S_W_A,
      S_W_B,
      S_W_INIT1,
      S_HOLD,
      S_P_RD,
      S_P_CHK,
      S_R_RD,
      S_R_CAP,
      S_DONE
   } state_t;

endpackage

// File: rtl/div_poll_timer.sv
// Hold-off down-counter and ready-poll counter used by the divider bus master.
module div_poll_timer #(
   parameter int HOLDOFF = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic hold_load,
   input  logic hold_dec,
   output logic hold_expired,
   input  logic poll_clr,
   input  logic poll_inc,
   output logic poll_last
);

   localparam int HW = $clog2(HOLDOFF + 1);
   localparam int PW = $clog2(TIMEOUT) + 1;
   // Loaded with HOLDOFF-1 so that the HOLD state lasts exactly HOLDOFF cycles
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF - 1);
   localparam logic [PW-1:0] POLL_LAST = PW'(TIMEOUT - 1);

   logic [HW-1:0] hold_cnt;
   logic [PW-1:0] poll_cnt;

   // Counter updates; the poll counter is one bit wider than needed so it never wraps
   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_cnt <= '0;
         poll_cnt <= '0;
      end else begin
         if (hold_load)
            hold_cnt <= HOLD_INIT;
         else if (hold_dec && hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;
         if (poll_clr)
            poll_cnt <= '0;
         else if (poll_inc)
            poll_cnt <= poll_cnt + 1'b1;
      end
   end

   assign hold_expired = (hold_cnt == '0);
   assign poll_last    = (poll_cnt == POLL_LAST);

endmodule

// File: rtl/div_job_master.sv
// Bus initiator: takes (dividend, divisor) jobs and runs the divider peripheral's
// register sequence (clear init, write operands, set init, poll ready, read result).
module div_job_master
   import div_bus_pkg::*;
#(
   parameter int HOLDOFF = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [31:0] job_dv,
   input  logic [31:0] job_dr,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_err,
   output logic        cs,
   output logic [2:0]  addr,
   output logic        rd,
   output logic        wr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata
);

   state_t      state, state_nx;
   logic [31:0] dv_q, dr_q;
   logic        hold_load, hold_dec, hold_expired;
   logic        poll_clr, poll_inc, poll_last;
   logic        cs_nx, rd_nx, wr_nx;
   logic [2:0]  addr_nx;
   logic [31:0] wdata_nx;
   logic        accept, timeout_hit;

   assign job_ready   = (state == S_IDLE);
   assign accept      = job_ready && job_valid;
   assign timeout_hit = (state == S_P_CHK) && !bus_rdata[0] && poll_last;

   div_poll_timer #(.HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) u_timer (
      .clk          (clk),
      .rst          (rst),
      .hold_load    (hold_load),
      .hold_dec     (hold_dec),
      .hold_expired (hold_expired),
      .poll_clr     (poll_clr),
      .poll_inc     (poll_inc),
      .poll_last    (poll_last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state logic and timer controls
   always_comb begin
      state_nx  = state;
      hold_load = 1'b0;
      hold_dec  = 1'b0;
      poll_clr  = 1'b0;
      poll_inc  = 1'b0;
      case (state)
         S_IDLE:    if (job_valid) state_nx = (job_dr == '0) ? S_DONE : S_W_INIT0;
         S_W_INIT0: state_nx = S_W_A;
         S_W_A:     state_nx = S_W_B;
         S_W_B:     state_nx = S_W_INIT1;
         S_W_INIT1: begin
            hold_load = 1'b1;
            poll_clr  = 1'b1;
            state_nx  = S_HOLD;
         end
         S_HOLD: begin
            if (hold_expired) state_nx = S_P_RD;
            else              hold_dec = 1'b1;
         end
         S_P_RD:    state_nx = S_P_CHK;
         S_P_CHK: begin
            if (bus_rdata[0]) begin
               state_nx = S_R_RD;
            end else begin
               poll_inc = 1'b1;
               state_nx = poll_last ? S_DONE : S_P_RD;
            end
         end
         S_R_RD:    state_nx = S_R_CAP;
         S_R_CAP:   state_nx = S_DONE;
         S_DONE:    if (res_ready) state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // Bus strobes for the upcoming cycle, decoded from the next state so the outputs can be registered
   always_comb begin
      cs_nx    = 1'b0;
      rd_nx    = 1'b0;
      wr_nx    = 1'b0;
      addr_nx  = '0;
      wdata_nx = '0;
      case (state_nx)
         S_W_INIT0: begin cs_nx = 1'b1; wr_nx = 1'b1; addr_nx = DIV_INIT; wdata_nx = 32'd0; end
         S_W_A:     begin cs_nx = 1'b1; wr_nx = 1'b1; addr_nx = DIV_A;    wdata_nx = dv_q;  end
         S_W_B:     begin cs_nx = 1'b1; wr_nx = 1'b1; addr_nx = DIV_B;    wdata_nx = dr_q;  end
         S_W_INIT1: begin cs_nx = 1'b1; wr_nx = 1'b1; addr_nx = DIV_INIT; wdata_nx = 32'd1; end
         S_P_RD:    begin cs_nx = 1'b1; rd_nx = 1'b1; addr_nx = DIV_READY;  end
         S_R_RD:    begin cs_nx = 1'b1; rd_nx = 1'b1; addr_nx = DIV_RESULT; end
         default:   ;
      endcase
   end

   // Registered bus outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         cs        <= 1'b0;
         rd        <= 1'b0;
         wr        <= 1'b0;
         addr      <= '0;
         bus_wdata <= '0;
      end else begin
         cs        <= cs_nx;
         rd        <= rd_nx;
         wr        <= wr_nx;
         addr      <= addr_nx;
         bus_wdata <= wdata_nx;
      end
   end

   // Operand latches and result registers; the result holds steady while DONE waits
   always_ff @(posedge clk) begin
      if (!rst) begin
         dv_q      <= '0;
         dr_q      <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= 1'b0;
      end else begin
         res_valid <= (state_nx == S_DONE);
         if (accept) begin
            dv_q <= job_dv;
            dr_q <= job_dr;
            if (job_dr == '0) begin
               res_data <= ERR_DIV0_RESULT;
               res_err  <= 1'b1;
            end
         end
         if (timeout_hit) begin
            res_data <= '0;
            res_err  <= 1'b1;
         end
         if (state == S_R_CAP) begin
            res_data <= bus_rdata;
            res_err  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_div_job_master.sv
// Self-checking bench for div_job_master with a register-level divider model.
module tb_div_job_master;
   localparam int H = 2;
   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        job_valid = 1'b0, res_ready = 1'b0;
   logic [31:0] job_dv = '0, job_dr = '0;
   logic        job_ready, res_valid, res_err, cs, rd, wr;
   logic [31:0] res_data, bus_wdata;
   logic [2:0]  addr;
   logic [31:0] bus_rdata;

   int tests = 0;
   int fails = 0;

   div_job_master #(.HOLDOFF(H), .TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
      .job_dv(job_dv), .job_dr(job_dr), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_err(res_err), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   // Bus trace entry
   typedef struct {
      logic        w;
      logic [2:0]  a;
      logic [31:0] d;
   } bus_op_t;
   bus_op_t trace[$];
   int proto_err = 0;

   // Divider peripheral model (not reset by the master's rst)
   int          lat_cfg = 0;
   bit          stuck = 1'b0;
   logic [31:0] m_a = '0, m_b = '0, m_res = '0, rdata_q = 32'hDEAD_BEEF;
   logic        m_init = 1'b0, m_rdy = 1'b0, m_run = 1'b0;
   int          m_cnt = 0;

   assign bus_rdata = rdata_q;

   // Record bus operations and check that each active cycle is exactly one of rd/wr
   always @(posedge clk) begin
      if (cs) begin
         trace.push_back('{wr, addr, bus_wdata});
         if (rd == wr) proto_err <= proto_err + 1;
      end else if (rd || wr) begin
         proto_err <= proto_err + 1;
      end
   end

   // Register behaviour of the peripheral: quotient computed on an init 0->1 edge, ready after lat_cfg cycles
   always @(posedge clk) begin
      if (cs && wr) begin
         case (addr)
            3'd0: m_a <= bus_wdata;
            3'd1: m_b <= bus_wdata;
            3'd2: begin
               m_init <= bus_wdata[0];
               if (bus_wdata[0] && !m_init) begin
                  m_res <= (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
                  m_rdy <= 1'b0;
                  m_run <= 1'b1;
                  m_cnt <= lat_cfg;
               end
            end
            default: ;
         endcase
      end else if (m_run) begin
         if (m_cnt == 0) begin
            if (!stuck) begin
               m_rdy <= 1'b1;
               m_run <= 1'b0;
            end
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
      if (cs && rd)
         rdata_q <= (addr == 3'd3) ? {31'd0, m_rdy} : (addr == 3'd4) ? m_res : 32'd0;
      else
         rdata_q <= 32'hDEAD_BEEF;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference result: {err, quotient}
   function automatic logic [32:0] ref_div(input logic [31:0] dv, input logic [31:0] dr, input bit stk);
      if (dr == 0) return {1'b1, 32'hFFFF_FFFF};
      if (stk)     return {1'b1, 32'h0};
      return {1'b0, dv / dr};
   endfunction

   // Expected trace: four writes, then ready polls, then one result read (or T polls on timeout)
   task automatic check_trace(input string nm, input logic [31:0] dv, input logic [31:0] dr, input bit stk);
      bus_op_t ew[4];
      bit good = 1'b1;
      int n = trace.size();
      int polls = 0;
      ew[0] = '{1'b1, 3'd2, 32'd0};
      ew[1] = '{1'b1, 3'd0, dv};
      ew[2] = '{1'b1, 3'd1, dr};
      ew[3] = '{1'b1, 3'd2, 32'd1};
      if (dr == 0) begin
         good = (n == 0);
      end else if (n < 5) begin
         good = 1'b0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (trace[i].w !== ew[i].w || trace[i].a !== ew[i].a || trace[i].d !== ew[i].d) good = 1'b0;
         for (int i = 4; i < n; i++) begin
            if (trace[i].w !== 1'b0) good = 1'b0;
            if (trace[i].a == 3'd3) polls++;
         end
         if (stk) good = good && (polls == T) && (n == 4 + T);
         else     good = good && (trace[n-1].a == 3'd4) && (polls == n - 5) && (polls >= 1) && (polls <= T);
      end
      tests++;
      if (!good) begin
         fails++;
         $display("FAIL %s: bus trace of %0d ops with %0d ready polls is not the required sequence", nm, n, polls);
      end
   endtask

   // Offer a job, wait for the result, hold res_ready low rr_dly cycles, then take it
   task automatic run_job(input logic [31:0] dv, input logic [31:0] dr, input int rr_dly,
                          output logic [31:0] d, output logic e, output int lat);
      lat = 0;
      d = '0;
      e = 1'b0;
      @(negedge clk);
      job_dv = dv;
      job_dr = dr;
      job_valid = 1'b1;
      for (int i = 0; i < 20 && !job_ready; i++) @(negedge clk);
      @(posedge clk);
      #1 job_valid = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (res_valid) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) begin
         tests++;
         fails++;
         $display("FAIL timeout: no res_valid for job %0h/%0h", dv, dr);
         return;
      end
      repeat (rr_dly) @(negedge clk);
      d = res_data;
      e = res_err;
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
   endtask

   typedef struct {
      logic [31:0] dv;
      logic [31:0] dr;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t        vecs[8];
   logic [31:0] d, d0;
   logic        e;
   logic [32:0] r;
   int          lat;
   bit          ok;

   initial begin
      vecs[0] = '{32'd100,        32'd7,          32'd14,         1'b0};
      vecs[1] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
      vecs[2] = '{32'd1000,       32'd10,         32'd100,        1'b0};
      vecs[3] = '{32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  1'b0};
      vecs[4] = '{32'd0,          32'd9,          32'd0,          1'b0};
      vecs[5] = '{32'd7,          32'd8,          32'd0,          1'b0};
      vecs[6] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
      vecs[7] = '{32'h1234_5678,  32'hFFFF_FFFF,  32'd0,          1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {cs, rd, wr, addr, bus_wdata, res_valid, res_err, res_data}, '0);
      chk("reset_job_ready", job_ready, 1'b1);
      rst = 1'b1;

      // Directed table, ready on first poll: exact latency, result and bus trace
      lat_cfg = 0;
      foreach (vecs[i]) begin
         trace.delete();
         run_job(vecs[i].dv, vecs[i].dr, i % 3, d, e, lat);
         chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
         chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
         if (vecs[i].dr == 0) chk($sformatf("vec%0d_lat_div0", i), (lat >= 1 && lat <= 2), 1'b1);
         else                 chk($sformatf("vec%0d_latency", i), lat, 9 + H);
         check_trace($sformatf("vec%0d_trace", i), vecs[i].dv, vecs[i].dr, 1'b0);
         @(negedge clk);
         chk($sformatf("vec%0d_valid_drop", i), res_valid, 1'b0);
      end

      // Ready never set: exactly T polls, then error with zero result
      stuck = 1'b1;
      trace.delete();
      run_job(32'd40, 32'd4, 0, d, e, lat);
      chk("timeout_data", d, 32'd0);
      chk("timeout_err", e, 1'b1);
      check_trace("timeout_trace", 32'd40, 32'd4, 1'b1);
      stuck = 1'b0;

      // Result held 20 cycles in DONE while another job is offered
      trace.delete();
      @(negedge clk);
      job_dv = 32'd90; job_dr = 32'd9; job_valid = 1'b1;
      @(posedge clk);
      #1 job_valid = 1'b0;
      lat = 0;
      for (int i = 1; i <= 100 && lat == 0; i++) begin
         @(negedge clk);
         if (res_valid) lat = i;
      end
      chk("hold_reached_done", (lat != 0), 1'b1);
      d0 = res_data;
      job_dv = 32'd3; job_dr = 32'd1; job_valid = 1'b1;
      trace.delete();
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!res_valid || res_data !== d0 || job_ready || res_err) ok = 1'b0;
      end
      chk("hold_stable", ok, 1'b1);
      chk("hold_data", d0, 32'd10);
      chk("hold_no_bus", trace.size(), 0);
      job_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      chk("hold_released", {res_valid, job_ready}, 2'b01);

      // Reset while polling, then recovery starts with an init clear
      stuck = 1'b1;
      trace.delete();
      job_dv = 32'd50; job_dr = 32'd5; job_valid = 1'b1;
      @(posedge clk);
      #1 job_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (trace.size() > 4 && trace[trace.size()-1].a == 3'd3) ok = 1'b1;
      end
      chk("midrst_polling_seen", ok, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_outputs", {cs, rd, wr, addr, bus_wdata, res_valid, res_err, res_data}, '0);
      chk("midrst_job_ready", job_ready, 1'b1);
      rst = 1'b1;
      stuck = 1'b0;
      trace.delete();
      run_job(32'd77, 32'd7, 0, d, e, lat);
      chk("midrst_next_data", {e, d}, {1'b0, 32'd11});
      check_trace("midrst_next_trace", 32'd77, 32'd7, 1'b0);

      // Randomized jobs against the reference model
      for (int k = 0; k < 40; k++) begin
         logic [31:0] dv, dr;
         dv = $urandom;
         case ($urandom_range(0, 3))
            0:       dr = 32'd0;
            1:       dr = $urandom_range(1, 100);
            default: dr = $urandom;
         endcase
         lat_cfg = $urandom_range(0, 6);
         trace.delete();
         run_job(dv, dr, $urandom_range(0, 3), d, e, lat);
         r = ref_div(dv, dr, 1'b0);
         chk($sformatf("rand%0d_result", k), {e, d}, r);
         check_trace($sformatf("rand%0d_trace", k), dv, dr, 1'b0);
      end

      chk("bus_protocol", proto_err, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

endmodule
